// File: rtl/stream_pkg.sv
// Shared definitions for the stream framer path.
//   SAMPLE_W      : default sample width, matching the upstream stage
//   sample_t      : sample word of the default width
//   level_width() : width needed to hold a FIFO occupancy of 0..depth
//   LEVEL_W       : level width for the default depth
package stream_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int DEFAULT_DEPTH = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int LEVEL_W = $clog2(DEFAULT_DEPTH + 1);

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with drop-on-full.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_wr_en/i_wr_data: write request (cannot be stalled)
//   i_rd_en          : consumer ready; pops only when an entry is present
//   o_valid/o_rd_data: head entry (o_rd_data undefined when o_valid=0)
//   o_level          : occupancy 0..DEPTH
//   o_drop           : a write was refused this cycle (full, no pop)
module sync_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_wr_en,
    input  logic [WIDTH-1:0]              i_wr_data,
    input  logic                          i_rd_en,
    output logic                          o_valid,
    output logic [WIDTH-1:0]              o_rd_data,
    output logic [level_width(DEPTH)-1:0] o_level,
    output logic                          o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Pointers alone cannot tell full from empty; the level counter does.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_pop   = i_rd_en & ~w_empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_push  = i_wr_en & (~w_full | w_pop);

    assign o_valid   = ~w_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_drop    = i_wr_en & w_full & ~w_pop;

    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/stream_framer_fifo.sv
// Buffers a valid-only sample stream and re-emits it on ready/valid,
// marking every FRAME_LEN-th transferred word with o_out_last.
//   i_clock, i_reset         : clock, synchronous active-high reset
//   i_in_data, i_in_valid    : upstream samples (no backpressure)
//   o_out_data, o_out_valid  : head word, data zeroed when not valid
//   i_out_ready              : downstream accept
//   o_out_last               : head word closes a frame
//   o_overflow               : sticky, a sample was dropped since reset
//   o_level                  : FIFO occupancy
module stream_framer_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int FRAME_LEN = 64
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_in_data,
    input  logic                       i_in_valid,
    output logic [WIDTH-1:0]           o_out_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic                       o_out_last,
    output logic                       o_overflow,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    // Keep at least one bit so FRAME_LEN=1 still elaborates cleanly.
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic             w_valid;
    logic [WIDTH-1:0] w_head;
    logic             w_drop;
    logic             w_xfer;
    logic             w_cnt_end;

    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_overflow;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (i_in_valid),
        .i_wr_data (i_in_data),
        .i_rd_en   (i_out_ready),
        .o_valid   (w_valid),
        .o_rd_data (w_head),
        .o_level   (o_level),
        .o_drop    (w_drop)
    );

    assign w_xfer    = w_valid & i_out_ready;
    assign w_cnt_end = (r_frame_cnt == CNT_W'(FRAME_LEN - 1));

    assign o_out_valid = w_valid;
    assign o_out_data  = w_valid ? w_head : '0;
    assign o_out_last  = w_valid & w_cnt_end;
    assign o_overflow  = r_overflow;

    // Counts transfers only; dropped samples never reach the output.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_frame_cnt <= '0;
        end else if (w_xfer) begin
            r_frame_cnt <= w_cnt_end ? '0 : r_frame_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_framer_fifo.sv
module tb_stream_framer_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int FLEN  = 64;
    localparam int LW    = $clog2(DEPTH+1);

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b0;
    logic [W-1:0]  i_in_data = '0;
    logic          i_in_valid = 1'b0;
    logic [W-1:0]  o_out_data;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic          o_out_last;
    logic          o_overflow;
    logic [LW-1:0] o_level;

    int errors = 0;
    int checks = 0;

    stream_framer_fifo #(.WIDTH(W), .DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_out_data  (o_out_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_last  (o_out_last),
        .o_overflow  (o_overflow),
        .o_level     (o_level)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: a queue of stored samples, a running count of
    // transfers since reset, and a sticky drop flag.
    logic [W-1:0] mq[$];
    int           m_xfer = 0;
    bit           m_ovf  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit vld, input logic [W-1:0] d, input bit rdy);
        int sz;
        bit pop;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_xfer = 0;
            m_ovf  = 0;
        end else begin
            pop = rdy && (sz > 0);
            if (pop) begin
                void'(mq.pop_front());
                m_xfer++;
            end
            if (vld) begin
                if (sz < DEPTH || pop) mq.push_back(d);
                else m_ovf = 1;
            end
        end
    endtask

    // Apply inputs for one cycle; outputs are settled 1 time unit after the edge.
    task automatic cyc(input bit rst, input bit vld, input logic [W-1:0] d, input bit rdy);
        i_reset = rst; i_in_valid = vld; i_in_data = d; i_out_ready = rdy;
        @(posedge i_clock);
        model_edge(rst, vld, d, rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit            ev;
        logic [W-1:0]  ed;
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : '0;
        check({tag, ".valid"}, 32'(o_out_valid), 32'(ev));
        check({tag, ".data"},  32'(o_out_data),  32'(ed));
        check({tag, ".last"},  32'(o_out_last),  32'(ev && (m_xfer % FLEN == FLEN-1)));
        check({tag, ".level"}, 32'(o_level),     32'(mq.size()));
        check({tag, ".ovf"},   32'(o_overflow),  32'(m_ovf));
    endtask

    typedef struct {
        bit           rst, vld, rdy;
        logic [W-1:0] d;
        bit           e_valid, e_last, e_ovf;
        logic [W-1:0] e_data;
        int           e_level;
    } vec_t;

    initial begin
        vec_t         tv[9];
        logic [W-1:0] got[$];
        int           lasts;
        logic [W-1:0] p_data;
        bit           p_valid, p_last, p_stall;
        bit           r_vld, r_rdy;

        // rst vld rdy data | valid last ovf data level
        tv[0] = '{1,0,0,16'h0000, 0,0,0,16'h0000,0};
        tv[1] = '{0,1,0,16'hAAAA, 1,0,0,16'hAAAA,1};
        tv[2] = '{0,1,0,16'hBBBB, 1,0,0,16'hAAAA,2};
        tv[3] = '{0,0,1,16'h0000, 1,0,0,16'hBBBB,1};
        tv[4] = '{0,1,1,16'hCCCC, 1,0,0,16'hCCCC,1};
        tv[5] = '{0,0,1,16'h0000, 0,0,0,16'h0000,0};
        tv[6] = '{0,0,1,16'h0000, 0,0,0,16'h0000,0};
        tv[7] = '{0,1,1,16'hDDDD, 1,0,0,16'hDDDD,1};
        tv[8] = '{1,1,0,16'hEEEE, 0,0,0,16'h0000,0};

        for (int i = 0; i < 9; i++) begin
            cyc(tv[i].rst, tv[i].vld, tv[i].d, tv[i].rdy);
            check($sformatf("vec%0d.valid", i), 32'(o_out_valid), 32'(tv[i].e_valid));
            check($sformatf("vec%0d.data",  i), 32'(o_out_data),  32'(tv[i].e_data));
            check($sformatf("vec%0d.last",  i), 32'(o_out_last),  32'(tv[i].e_last));
            check($sformatf("vec%0d.level", i), 32'(o_level),     32'(tv[i].e_level));
            check($sformatf("vec%0d.ovf",   i), 32'(o_overflow),  32'(tv[i].e_ovf));
        end

        // Idle with ready high: nothing ever appears.
        cyc(1, 0, '0, 1);
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 0, '0, 1);
            if (o_out_valid !== 1'b0 || o_level !== '0 || o_overflow !== 1'b0)
                check("idle", {o_out_valid, o_overflow, 30'(o_level)}, 32'd0);
        end
        check("idle.end", {o_out_valid, o_overflow, 30'(o_level)}, 32'd0);

        // Streaming pass-through, one cycle latency, last on 0x40 and 0x80.
        lasts = 0;
        for (int v = 1; v <= 128; v++) begin
            cyc(0, 1, W'(v), 1);
            check("pass.valid", 32'(o_out_valid), 32'd1);
            check("pass.data",  32'(o_out_data),  32'(v));
            check("pass.last",  32'(o_out_last),  32'(v % 64 == 0));
            check("pass.level", 32'(o_level),     32'd1);
            if (o_out_last === 1'b1) lasts++;
        end
        cyc(0, 0, '0, 1);
        check_model("pass.drain");
        check("pass.lasts", 32'(lasts), 32'd2);

        // Overflow: stalled consumer, 20 pushes into 16 entries.
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, W'(16'h0100 + i), 0);
            check("ovf.level", 32'(o_level), 32'(i < 16 ? i+1 : 16));
            check("ovf.flag",  32'(o_overflow), 32'(i >= 16));
            check_model("ovf");
        end
        got.delete();
        for (int i = 0; i < 18; i++) begin
            if (o_out_valid === 1'b1) got.push_back(o_out_data);
            cyc(0, 0, '0, 1);
            check_model("ovf.drain");
        end
        check("ovf.count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check("ovf.order", 32'(got[i]), 32'(16'h0100 + i));
        check("ovf.sticky", 32'(o_overflow), 32'd1);

        // Full with simultaneous push and pop: no drop, level pinned at 16.
        cyc(1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, W'(16'h0200 + i), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, W'(16'h0300 + i), 1);
            check("full.level", 32'(o_level), 32'd16);
            check("full.ovf",   32'(o_overflow), 32'd0);
            check_model("full");
        end

        // Randomised traffic against the model, plus stall stability.
        cyc(1, 0, '0, 0);
        p_stall = 0;
        for (int i = 0; i < 5000; i++) begin
            r_vld  = ($urandom_range(99) < 30);
            r_rdy  = ($urandom_range(1) == 1);
            p_data = o_out_data; p_valid = o_out_valid; p_last = o_out_last;
            p_stall = (o_out_valid === 1'b1) && !r_rdy;
            cyc(0, r_vld, W'($urandom), r_rdy);
            check_model("rand");
            if (p_stall) begin
                check("stall.data",  32'(o_out_data),  32'(p_data));
                check("stall.valid", 32'(o_out_valid), 32'(p_valid));
                check("stall.last",  32'(o_out_last),  32'(p_last));
            end
        end

        // Reset mid-stream flushes and restarts framing.
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, W'(16'h0400 + i), (i < 3));
        cyc(1, 1, 16'hDEAD, 0);
        check("rst.valid", 32'(o_out_valid), 32'd0);
        check("rst.level", 32'(o_level),     32'd0);
        check("rst.ovf",   32'(o_overflow),  32'd0);
        check("rst.data",  32'(o_out_data),  32'd0);
        lasts = 0;
        for (int v = 1; v <= 64; v++) begin
            cyc(0, 1, W'(16'h0500 + v), 1);
            check("rst.data2", 32'(o_out_data), 32'(16'h0500 + v));
            check("rst.last",  32'(o_out_last), 32'(v == 64));
            check_model("rst.frame");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_framer_fifo.md
Name: stream_framer_fifo

Overview:
- Downstream stage that consumes the valid-only sample stream from the preceding processing block (no backpressure available upstream).
- Buffers samples in a small synchronous FIFO and re-emits them on a ready/valid interface.
- Tags every FRAME_LEN-th transferred word with o_out_last so the next consumer sees framed packets.
- Flags overflow when the consumer stalls long enough to fill the buffer.

Parameters:
- WIDTH, 16, sample width in bits; matches the upstream stage.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FRAME_LEN, 64, words per frame; at least 1.

Ports:
- i_clock  input  1  single clock, rising-edge.
- i_reset  input  1  synchronous, active-high reset.
- i_in_data  input  WIDTH  upstream sample.
- i_in_valid  input  1  upstream sample qualifier; every asserted cycle is a sample; there is no stall.
- o_out_data  output  WIDTH  head-of-FIFO sample; forced to 0 when o_out_valid=0.
- o_out_valid  output  1  head word available.
- i_out_ready  input  1  downstream accepts; a transfer occurs when o_out_valid&i_out_ready at a rising edge.
- o_out_last  output  1  the current head word is the final word of a frame.
- o_overflow  output  1  sticky: at least one sample was dropped since reset.
- o_level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - The reset asserted at edge k takes effect after edge k.
  - Pointers, o_level, frame counter and o_overflow all go to 0.
  - o_out_valid=0, o_out_last=0, o_out_data=0.
  - Reset mid-operation flushes all buffered data; no partial frame is completed.
  - In-flight i_in_valid during reset is ignored.
- Push: i_in_valid=1 at an edge writes i_in_data, unless the FIFO is full and no pop occurs at that same edge.
- Pop: o_out_valid & i_out_ready at an edge advances the read pointer.
- Latency:
  - A sample written at edge k into an empty FIFO is presented in the cycle after edge k (o_out_valid=1, o_out_data=sample).
  - The path is first-word fall-through: o_out_valid is registered-derived (level!=0) with no combinational path from inputs.
- Occupancy:
  - o_level updates +1 on push-only, -1 on pop-only, unchanged on push+pop or on neither.
  - Range 0..DEPTH.
- Full boundary:
  - Level=DEPTH with i_in_valid=1 and a pop at the same edge: the push is accepted and level stays at DEPTH.
  - Level=DEPTH with i_in_valid=1 and no pop: the sample is dropped and o_overflow goes to 1 after that edge.
  - Sticky behaviour: o_overflow stays 1 until reset.
  - Stored contents are never corrupted by a dropped sample.
- Empty boundary:
  - Level=0 means o_out_valid=0 and i_out_ready has no effect.
  - Level=0 with a push: no pop occurs that cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by the level counter.
- Framing:
  - frame_cnt counts transfers, 0..FRAME_LEN-1.
  - It increments on each transfer and wraps to 0 on the transfer where o_out_last=1.
  - o_out_last = o_out_valid & (frame_cnt==FRAME_LEN-1).
  - Dropped samples do not advance frame_cnt.
  - FRAME_LEN=1 means o_out_last=o_out_valid.
- Downstream stall: holding i_out_ready=0 keeps o_out_data, o_out_valid and o_out_last stable.
- Ordering: strict in-order delivery; no duplication.

Decomposition:
- Shared package stream_pkg holds:
  - the default sample width constant;
  - a typedef for sample words;
  - the clog2-based level-width helper constant.
- One natural sub-module, sync_fifo: storage, pointers, level and the full/empty/drop logic.
- stream_framer_fifo instantiates sync_fifo and adds the frame counter, last generation, output zero-masking and the sticky overflow register.

Test Plan:
- Reset, then 1000 cycles with i_in_valid=0 and i_out_ready=1 -> o_out_valid never asserts; o_level=0; o_overflow=0.
- i_out_ready=1; push 0x0001..0x0080, one per cycle -> same 128 values out, in order, each 1 cycle after its write; o_out_last on 0x0040 and 0x0080 only; o_level never exceeds 1.
- i_out_ready=0; push 20 samples 0x0100..0x0113 (DEPTH=16) -> o_level saturates at 16; o_overflow=1 from the 17th push; then i_out_ready=1 delivers exactly 0x0100..0x010F.
- Full FIFO with i_out_ready=1 and a push in the same cycle -> no drop; o_overflow stays 0; o_level stays 16.
- Random i_out_ready at 50% and i_in_valid at 30%, 5000 cycles -> scoreboard matches with zero drops; o_out_last every 64th transfer; outputs stable while stalled.
- Load 10 samples, assert i_reset for 1 cycle mid-stream -> o_out_valid=0, o_level=0, o_overflow=0 after the edge; the next frame restarts with frame_cnt=0, so last falls on the 64th post-reset transfer.
